// File: rtl/mpeg_bs_pkg.sv
// Shared bitstream constants for the MPEG motion-vector path.
// The decoder and the window buffer both import this package so their widths stay in step.
package mpeg_bs_pkg;

  localparam int MV_WIN_W      = 11;
  localparam int MV_SHIFT_W    = 5;
  localparam int STREAM_WORD_W = 32;
  localparam int BS_BUF_W      = 64;
  localparam int BS_LVL_W      = 7;

  typedef logic [BS_LVL_W-1:0] level_t;

endpackage

// File: rtl/mv_bit_window_if.sv
// Stream-in and window-out handshake between the fetcher, the window buffer and get_motion_code.
// The master modport is the fetcher/decoder side; the slave modport is the buffer.
interface mv_bit_window_if
  import mpeg_bs_pkg::*;
#(
  parameter int WORD_W  = STREAM_WORD_W,
  parameter int WIN_W   = MV_WIN_W,
  parameter int SHIFT_W = MV_SHIFT_W
);

  logic [WORD_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIN_W-1:0]   win;
  logic               win_valid;
  logic               consume_valid;
  logic [SHIFT_W-1:0] consume_bits;

  modport master (
    output in_data, in_valid, consume_valid, consume_bits,
    input  in_ready, win, win_valid
  );

  modport slave (
    input  in_data, in_valid, consume_valid, consume_bits,
    output in_ready, win, win_valid
  );

endinterface

// File: rtl/mv_bit_window.sv
// Left-aligned bit store that feeds get_motion_code its next WIN_W unread bits and
// retires the decoder's outshift every cycle, while appending 32-bit stream words behind them.
module mv_bit_window
  import mpeg_bs_pkg::*;
#(
  parameter int WORD_W  = STREAM_WORD_W,
  parameter int BUF_W   = BS_BUF_W,
  parameter int WIN_W   = MV_WIN_W,
  parameter int SHIFT_W = MV_SHIFT_W,
  parameter int LVL_W   = BS_LVL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  mv_bit_window_if.slave      bus,
  output logic [LVL_W-1:0]    level,
  output logic [31:0]         bits_consumed,
  output logic                err
);

  logic [BUF_W-1:0] store_r;
  logic [LVL_W-1:0] level_r;
  logic [31:0]      consumed_r;
  logic             err_r;

  logic             in_ready_s;
  logic             win_valid_s;
  logic             consume_ok_s;
  logic             consume_bad_s;
  logic             load_ok_s;
  logic [BUF_W-1:0] store_tmp_s;
  logic [LVL_W-1:0] level_tmp_s;
  logic [BUF_W-1:0] word_al_s;
  logic [BUF_W-1:0] store_nxt_s;
  logic [LVL_W-1:0] level_nxt_s;

  // in_ready looks only at the current level, so a same-cycle consume never widens admission.
  assign in_ready_s    = (level_r <= LVL_W'(BUF_W - WORD_W));
  assign win_valid_s   = (level_r >= LVL_W'(WIN_W));
  assign consume_ok_s  = bus.consume_valid && win_valid_s &&
                         (bus.consume_bits >= SHIFT_W'(1)) &&
                         (bus.consume_bits <= SHIFT_W'(WIN_W));
  assign consume_bad_s = bus.consume_valid && !consume_ok_s;
  assign load_ok_s     = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.win_valid = win_valid_s;
  assign bus.win       = store_r[BUF_W-1 -: WIN_W];
  assign level         = level_r;
  assign bits_consumed = consumed_r;
  assign err           = err_r;

  // Retire first, then append the new word directly behind whatever bits remain.
  always_comb begin
    store_tmp_s = store_r;
    level_tmp_s = level_r;
    store_nxt_s = store_r;
    level_nxt_s = level_r;
    if (consume_ok_s) begin
      store_tmp_s = store_r << bus.consume_bits;
      level_tmp_s = level_r - LVL_W'(bus.consume_bits);
    end else begin
      store_tmp_s = store_r;
      level_tmp_s = level_r;
    end
    // Left-aligned word shifted right by the retained level == in_data << (BUF_W-WORD_W-level).
    word_al_s = {bus.in_data, {(BUF_W - WORD_W){1'b0}}} >> level_tmp_s;
    if (load_ok_s) begin
      store_nxt_s = store_tmp_s | word_al_s;
      level_nxt_s = level_tmp_s + LVL_W'(WORD_W);
    end else begin
      store_nxt_s = store_tmp_s;
      level_nxt_s = level_tmp_s;
    end
  end

  // State update; flush clears the bits but keeps the running count and the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_r    <= {BUF_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      consumed_r <= 32'd0;
      err_r      <= 1'b0;
    end else if (flush) begin
      store_r    <= {BUF_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
    end else begin
      store_r    <= store_nxt_s;
      level_r    <= level_nxt_s;
      if (consume_ok_s) begin
        consumed_r <= consumed_r + 32'(bus.consume_bits);
      end
      if (consume_bad_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mv_bit_window.sv
// Scoreboard bench for mv_bit_window: a bit-queue reference predicts every cycle's outputs,
// which are queued at drive time and compared one cycle later.
module tb_mv_bit_window;
  import mpeg_bs_pkg::*;

  typedef struct packed {
    logic [10:0] win;
    logic        wv;
    logic        ir;
    logic [6:0]  lvl;
    logic [31:0] bc;
    logic        er;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [6:0]  level;
  logic [31:0] bits_consumed;
  logic        err;

  mv_bit_window_if bus ();

  mv_bit_window dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus),
    .level         (level),
    .bits_consumed (bits_consumed),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          mq[$];
  logic [31:0] m_bits;
  logic        m_err;
  exp_t        sb[$];
  int          words_taken;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int i = 0; i < 11; i++) e.win[10-i] = (i < mq.size()) ? mq[i] : 1'b0;
    e.wv  = (mq.size() >= 11);
    e.ir  = (mq.size() <= 32);
    e.lvl = 7'(mq.size());
    e.bc  = m_bits;
    e.er  = m_err;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_val("win",           64'(bus.win),       64'(e.win));
      check_val("win_valid",     64'(bus.win_valid), 64'(e.wv));
      check_val("in_ready",      64'(bus.in_ready),  64'(e.ir));
      check_val("level",         64'(level),         64'(e.lvl));
      check_val("bits_consumed", 64'(bits_consumed), 64'(e.bc));
      check_val("err",           64'(err),           64'(e.er));
    end
  endtask

  task automatic step(input logic f, input logic iv, input logic [31:0] d,
                      input logic cv, input logic [4:0] n);
    int sz;
    @(negedge clk);
    flush = f;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.consume_valid = cv;
    bus.consume_bits = n;
    sz = mq.size();
    check_val("in_ready_pre", 64'(bus.in_ready), 64'(sz <= 32));
    if (f) begin
      mq.delete();
    end else begin
      if (cv) begin
        if (sz >= 11 && n >= 5'd1 && n <= 5'd11) begin
          repeat (int'(n)) void'(mq.pop_front());
          m_bits += 32'(n);
        end else begin
          m_err = 1'b1;
        end
      end
      if (iv && sz <= 32) begin
        for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
        words_taken++;
      end
    end
    sb.push_back(snapshot());
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_bits = 32'd0;
    m_err = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;
    bus.consume_valid = 1'b0;
    bus.consume_bits = 5'd0;
    model_reset();
    words_taken = 0;
    repeat (2) @(negedge clk);
    check_val("rst_level",    64'(level),         64'd0);
    check_val("rst_win",      64'(bus.win),       64'd0);
    check_val("rst_winvalid", 64'(bus.win_valid), 64'd0);
    check_val("rst_inready",  64'(bus.in_ready),  64'd1);
    check_val("rst_bits",     64'(bits_consumed), 64'd0);
    check_val("rst_err",      64'(err),           64'd0);
    rst = 1'b1;

    // 1: first load
    step(1'b0, 1'b1, 32'hF0F0_0000, 1'b0, 5'd0);
    check_val("t1_win",   64'(bus.win), 64'h787);
    check_val("t1_level", 64'(level),   64'd32);
    // 2: consume 3
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd3);
    check_val("t2_win",   64'(bus.win),       64'h43C);
    check_val("t2_level", 64'(level),         64'd29);
    check_val("t2_bits",  64'(bits_consumed), 64'd3);
    // 3: simultaneous load and consume
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd11);
    check_val("t3_level", 64'(level), 64'd50);
    // 4: fill to 64, hold in_valid while full, illegal consumes
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd11);
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd7);
    step(1'b0, 1'b1, 32'hA5C3_1E69, 1'b0, 5'd0);
    check_val("t4_full", 64'(level), 64'd64);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 5'd0);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 5'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd12);
    check_val("t4_err12", 64'(err),   64'd1);
    check_val("t4_lvl12", 64'(level), 64'd64);
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd0);
    check_val("t4_err0",  64'(err),   64'd1);
    // 5: flush at level 40 with competing load and consume
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd11);
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd11);
    step(1'b0, 1'b0, 32'd0, 1'b1, 5'd2);
    check_val("t5_pre_level", 64'(level), 64'd40);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd5);
    check_val("t5_level", 64'(level),   64'd0);
    check_val("t5_win",   64'(bus.win), 64'd0);
    step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 5'd4);
    // 6: asynchronous reset mid-stream
    step(1'b0, 1'b1, 32'h0F1E_2D3C, 1'b1, 5'd6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.consume_valid = 1'b0;
    flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_val("arst_level",    64'(level),         64'd0);
    check_val("arst_win",      64'(bus.win),       64'd0);
    check_val("arst_winvalid", 64'(bus.win_valid), 64'd0);
    check_val("arst_inready",  64'(bus.in_ready),  64'd1);
    check_val("arst_bits",     64'(bits_consumed), 64'd0);
    check_val("arst_err",      64'(err),           64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    // streaming soak
    words_taken = 0;
    cyc = 0;
    while (words_taken < 1000 && cyc < 20000) begin
      step(1'b0, ($urandom_range(0, 7) != 0), $urandom, 1'b1, 5'($urandom_range(1, 11)));
      cyc++;
    end
    check_val("soak_words", 64'(words_taken >= 1000), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
